// File: rtl/traffic_4way_pkg.sv
// traffic_4way_pkg: lamp codes, controller states and phase-sequencing helpers.
package traffic_4way_pkg;
  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  // AR_x is the all-red clearance that hands over to approach x next
  typedef enum logic [3:0] {
    N_G, N_Y, E_G, E_Y, S_G, S_Y, W_G, W_Y, AR_E, AR_S, AR_W, AR_N
  } state_t;
  function automatic state_t next_state(state_t s, logic ar_en);
    case (s)
      N_G:     return N_Y;
      N_Y:     return ar_en ? AR_E : E_G;
      AR_E:    return E_G;
      E_G:     return E_Y;
      E_Y:     return ar_en ? AR_S : S_G;
      AR_S:    return S_G;
      S_G:     return S_Y;
      S_Y:     return ar_en ? AR_W : W_G;
      AR_W:    return W_G;
      W_G:     return W_Y;
      W_Y:     return ar_en ? AR_N : N_G;
      default: return N_G;
    endcase
  endfunction
  function automatic logic [2:0] lamp_for(state_t s, state_t g, state_t y);
    return s == g ? LAMP_GREEN : s == y ? LAMP_YELLOW : LAMP_RED;
  endfunction
  function automatic int max3(int a, int b, int c);
    return a > b ? (a > c ? a : c) : (b > c ? b : c);
  endfunction
endpackage

// File: rtl/traffic_4way_ctrl_if.sv
// traffic_4way_ctrl_if: bundle of the four approach lamp codes.
interface traffic_4way_ctrl_if;
  logic [2:0] north;
  logic [2:0] south;
  logic [2:0] east;
  logic [2:0] west;
  modport master (output north, south, east, west);
  modport slave  (input  north, south, east, west);
endinterface

// File: rtl/traffic_phase_timer.sv
// traffic_phase_timer: up-counting dwell timer, done flags the last cycle of a phase.
module traffic_phase_timer #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CW-1:0] dur,
  input  logic          restart,
  output logic          done
);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = restart ? '0 : cnt_q + CW'(1);
  always_ff @(posedge clk)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign done = cnt_q == dur - CW'(1);
endmodule

// File: rtl/traffic_4way_ctrl.sv
// traffic_4way_ctrl: rotating N/E/S/W signal controller; define ALL_RED_CLEARANCE_EN for all-red gaps.
module traffic_4way_ctrl
  import traffic_4way_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int GREEN_SEC  = 5,
  parameter int YELLOW_SEC = 2,
  parameter int ALLRED_SEC = 1
) (
  input  logic       clk,
  input  logic       reset,
  output logic [2:0] North,
  output logic [2:0] South,
  output logic [2:0] East,
  output logic [2:0] West
);
  localparam int GREEN_CYC  = CLK_FREQ * GREEN_SEC;
  localparam int YELLOW_CYC = CLK_FREQ * YELLOW_SEC;
  localparam int ALLRED_CYC = CLK_FREQ * ALLRED_SEC;
  localparam int CW = $clog2(max3(GREEN_CYC, YELLOW_CYC, ALLRED_CYC) + 1);
`ifdef ALL_RED_CLEARANCE_EN
  localparam logic AR_EN = 1'b1;
`else
  localparam logic AR_EN = 1'b0;
`endif
  state_t state_q, state_d;
  logic [CW-1:0] dur;
  logic done;
  always_comb begin
    dur = state_q inside {N_Y, E_Y, S_Y, W_Y} ? CW'(YELLOW_CYC) :
          state_q inside {AR_E, AR_S, AR_W, AR_N} ? CW'(ALLRED_CYC) : CW'(GREEN_CYC);
    state_d = done ? next_state(state_q, AR_EN) : state_q;
  end
  // the timer restarts exactly when the phase advances
  traffic_phase_timer #(.CW(CW)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .dur    (dur),
    .restart(done),
    .done   (done)
  );
  always_ff @(posedge clk)
    if (reset) state_q <= N_G;
    else state_q <= state_d;
  always_comb begin
    North = lamp_for(state_q, N_G, N_Y);
    East  = lamp_for(state_q, E_G, E_Y);
    South = lamp_for(state_q, S_G, S_Y);
    West  = lamp_for(state_q, W_G, W_Y);
  end
endmodule

// File: tb/tb_traffic_4way_ctrl.sv
// tb_traffic_4way_ctrl: directed checks of the rotating signal sequence with CLK_FREQ=10.
module tb_traffic_4way_ctrl;
  import traffic_4way_pkg::*;
  localparam int G = 50;
  localparam int Y = 20;
`ifdef ALL_RED_CLEARANCE_EN
  localparam int AR = 10;
`else
  localparam int AR = 0;
`endif
  localparam int SLOT = G + Y + AR;
  localparam int PERIOD = 4 * SLOT;
  localparam logic [11:0] NG_ONLY = {LAMP_GREEN, LAMP_RED, LAMP_RED, LAMP_RED};
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  int t = 0;
  logic [11:0] obs;
  traffic_4way_ctrl_if lamps();
  traffic_4way_ctrl #(.CLK_FREQ(10)) dut (
    .clk  (clk),
    .reset(reset),
    .North(lamps.north),
    .South(lamps.south),
    .East (lamps.east),
    .West (lamps.west)
  );
  assign obs = {lamps.north, lamps.east, lamps.south, lamps.west};
  always #50ns clk = ~clk;
  initial begin
    #5ms;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end
  // expected {N,E,S,W} t edges after reset release, from slot arithmetic
  function automatic logic [11:0] exp_lamps(int tt);
    int s, a, r;
    logic [2:0] l;
    logic [11:0] v;
    s = tt % PERIOD;
    a = s / SLOT;
    r = s % SLOT;
    l = r < G ? LAMP_GREEN : r < G + Y ? LAMP_YELLOW : LAMP_RED;
    v = {4{LAMP_RED}};
    v[(3 - a) * 3 +: 3] = l;
    return v;
  endfunction
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
    t++;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (obs !== NG_ONLY) begin
      n_bad++;
      $display("FAIL reset_state: got %h want %h", obs, NG_ONLY);
    end
    reset = 1'b0;
    t = 0;
    n_cmp++;
    if (obs !== NG_ONLY) begin
      n_bad++;
      $display("FAIL release_state: got %h want %h", obs, NG_ONLY);
    end
  endtask
  task automatic test_first_phase;
    while (t < SLOT + 1) begin
      tick();
      n_cmp++;
      if (obs !== exp_lamps(t)) begin
        n_bad++;
        $display("FAIL first_phase t=%0d: got %h want %h", t, obs, exp_lamps(t));
      end
      if (t == G - 1 || t == G || t == G + Y - 1) begin
        n_cmp++;
        if (lamps.north !== (t == G - 1 ? LAMP_GREEN : LAMP_YELLOW)) begin
          n_bad++;
          $display("FAIL north_edge t=%0d: got %b", t, lamps.north);
        end
      end
`ifdef ALL_RED_CLEARANCE_EN
      if (t == G + Y) begin
        n_cmp++;
        if (obs !== {4{LAMP_RED}}) begin
          n_bad++;
          $display("FAIL all_red t=%0d: got %h want %h", t, obs, {4{LAMP_RED}});
        end
      end
`endif
      if (t == SLOT) begin
        n_cmp++;
        if (lamps.east !== LAMP_GREEN || lamps.north !== LAMP_RED) begin
          n_bad++;
          $display("FAIL east_handover: got N=%b E=%b want N=100 E=001", lamps.north, lamps.east);
        end
      end
    end
  endtask
  task automatic test_full_cycle;
    while (t < PERIOD) begin
      tick();
      n_cmp++;
      if (obs !== exp_lamps(t)) begin
        n_bad++;
        $display("FAIL full_cycle t=%0d: got %h want %h", t, obs, exp_lamps(t));
      end
    end
    n_cmp++;
    if (obs !== NG_ONLY) begin
      n_bad++;
      $display("FAIL wrap_to_ng: got %h want %h", obs, NG_ONLY);
    end
  endtask
  task automatic test_mid_reset;
    while (t < PERIOD + 2 * SLOT + G + 5) tick();
    n_cmp++;
    if (lamps.south !== LAMP_YELLOW) begin
      n_bad++;
      $display("FAIL in_s_y: got South=%b want 010", lamps.south);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    t = 0;
    n_cmp++;
    if (obs !== NG_ONLY) begin
      n_bad++;
      $display("FAIL mid_reset: got %h want %h", obs, NG_ONLY);
    end
    while (t < G + 1) begin
      tick();
      n_cmp++;
      if (obs !== exp_lamps(t)) begin
        n_bad++;
        $display("FAIL after_mid_reset t=%0d: got %h want %h", t, obs, exp_lamps(t));
      end
    end
  endtask
  task automatic test_glitch;
    int stop;
    @(posedge clk);
    #10ns reset = 1'b1;
    #50ns reset = 1'b0;
    @(negedge clk);
    t += 2;
    stop = t + SLOT;
    while (t < stop) begin
      n_cmp++;
      if (obs !== exp_lamps(t)) begin
        n_bad++;
        $display("FAIL narrow_pulse t=%0d: got %h want %h", t, obs, exp_lamps(t));
      end
      tick();
    end
    #25ns reset = 1'b1;
    #50ns reset = 1'b0;
    @(negedge clk);
    t = 0;
    n_cmp++;
    if (obs !== NG_ONLY) begin
      n_bad++;
      $display("FAIL straddle_pulse: got %h want %h", obs, NG_ONLY);
    end
    while (t < G + 2) begin
      tick();
      n_cmp++;
      if (obs !== exp_lamps(t)) begin
        n_bad++;
        $display("FAIL after_straddle t=%0d: got %h want %h", t, obs, exp_lamps(t));
      end
    end
  endtask
  task automatic test_invariant;
    int nonred;
    for (int i = 0; i < 1000; i++) begin
      tick();
      nonred = int'(lamps.north != LAMP_RED) + int'(lamps.east != LAMP_RED) +
               int'(lamps.south != LAMP_RED) + int'(lamps.west != LAMP_RED);
      n_cmp++;
      if (!$onehot(lamps.north) || !$onehot(lamps.east) || !$onehot(lamps.south) ||
          !$onehot(lamps.west) || nonred > 1 || obs !== exp_lamps(t)) begin
        n_bad++;
        $display("FAIL invariant t=%0d: got %h want %h", t, obs, exp_lamps(t));
      end
    end
  endtask
  initial begin
    test_reset();
    test_first_phase();
    test_full_cycle();
    test_mid_reset();
    test_glitch();
    test_invariant();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
